// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, Rcon table, word
// helpers and the schedule state encoding.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    REV
  } ks_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] key, input logic [1:0] idx);
    return key[32*idx +: 32];
  endfunction

  function automatic logic [127:0] pack_words(input logic [31:0] w0, input logic [31:0] w1,
                                              input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // Byte 0 sits in the low bits, so RotWord moves the low byte to the top.
  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[7:0], x[31:8]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 round-key source for decryption: runs the schedule forward to round 10,
// then streams round keys 10..0, stepping the single stored key backward per beat.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter bit SKIP_FWD   = 1'b0,
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  localparam logic [3:0] LAST_RND = 4'(AES_NR);

  if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
    $error("aes_inv_key_sched supports AES-128 only: NUM_ROUNDS must be 10");
  end

  ks_state_e    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rcnt_q, rcnt_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1p, w2p, w3p;
  logic [31:0] sbox_x, rot_x, sub_x, t;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] r0;

  assign w0 = get_word(key_q, 2'd0);
  assign w1 = get_word(key_q, 2'd1);
  assign w2 = get_word(key_q, 2'd2);
  assign w3 = get_word(key_q, 2'd3);

  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // One S-box bank serves both directions; only its input word changes.
  assign sbox_x = (state_q == REV) ? w3p : w3;
  assign rot_x  = rot_word(sbox_x);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .data_i (rot_x[8*b +: 8]),
      .data_o (sub_x[8*b +: 8])
    );
  end

  assign t  = sub_x ^ {24'h0, rcon(rcnt_q)};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign r0 = w0 ^ t;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d = key_in;
          if (SKIP_FWD) begin
            rcnt_d  = LAST_RND;
            state_d = REV;
          end else begin
            rcnt_d  = 4'd1;
            state_d = FWD;
          end
        end
      end
      FWD: begin
        key_d = pack_words(f0, f1, f2, f3);
        if (rcnt_q == LAST_RND) begin
          state_d = REV;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      REV: begin
        if (rk_ready) begin
          if (rcnt_q != 4'd0) begin
            key_d  = pack_words(r0, w1p, w2p, w3p);
            rcnt_d = rcnt_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Outputs decode straight from state registers, so reset clears them at once.
  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == REV);
  assign rk_data  = rk_valid ? key_q : '0;
  assign rk_round = rk_valid ? rcnt_q : 4'd0;
  assign rk_last  = rk_valid && (rcnt_q == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched against a byte-oriented AES-128
// key-expansion model whose S-box is derived from GF(2^8) inversion.
module tb_aes_inv_key_sched;

  localparam logic [127:0] FIPS_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] FIPS_RK10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] FIPS_RK1  = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] ZERO_RK10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;

  logic         clk;
  logic         rst_n;
  logic         start, startSkip, rk_ready;
  logic [127:0] key_in;

  logic         busy, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         busyS, validS, lastS;
  logic [127:0] dataS;
  logic [3:0]   roundS;

  bit           useSkip;
  logic         vBusy, vValid, vLast;
  logic [127:0] vData;
  logic [3:0]   vRound;

  int nVec, nErr;
  logic [7:0]   sboxTab [256];
  logic [127:0] rkModel [11];
  logic [127:0] beatData [16];
  logic [3:0]   beatRound [16];
  logic         beatLast [16];
  int latency, nBeats, stallErr, span;
  bit timedOut;

  aes_inv_key_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round), .rk_last(rk_last)
  );

  aes_inv_key_sched #(.SKIP_FWD(1'b1), .NUM_ROUNDS(10)) dutSkip (
    .clk(clk), .rst_n(rst_n), .start(startSkip), .key_in(key_in), .busy(busyS),
    .rk_valid(validS), .rk_ready(rk_ready), .rk_data(dataS), .rk_round(roundS), .rk_last(lastS)
  );

  assign vBusy  = useSkip ? busyS  : busy;
  assign vValid = useSkip ? validS : rk_valid;
  assign vLast  = useSkip ? lastS  : rk_last;
  assign vData  = useSkip ? dataS  : rk_data;
  assign vRound = useSkip ? roundS : rk_round;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic void buildSbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      sboxTab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  // Textbook byte-array expansion into 176 bytes, then sliced into 11 round keys.
  function automatic void expandKey(input logic [127:0] key);
    logic [7:0] eb [176];
    logic [7:0] tmp [4];
    logic [7:0] rc, hold;
    rc = 8'h01;
    for (int n = 0; n < 16; n++) eb[n] = key[8*n +: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = eb[i-4+j];
      if (i % 16 == 0) begin
        hold = tmp[0]; tmp[0] = tmp[1]; tmp[1] = tmp[2]; tmp[2] = tmp[3]; tmp[3] = hold;
        for (int j = 0; j < 4; j++) tmp[j] = sboxTab[tmp[j]];
        tmp[0] = tmp[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) eb[i+j] = eb[i-16+j] ^ tmp[j];
    end
    for (int r = 0; r < 11; r++)
      for (int n = 0; n < 16; n++) rkModel[r][8*n +: 8] = eb[16*r+n];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic kick(input bit skip, input logic [127:0] key);
    useSkip = skip;
    key_in  = key;
    if (skip) startSkip = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; startSkip = 1'b0;
  endtask

  // Drives rk_ready and records accepted beats; called one edge after start is sampled.
  task automatic collect(input int readyPct, input bit pokeStart, input bit startOnLast,
                         input logic [127:0] keyB);
    logic [127:0] hd;
    logic [3:0]   hr;
    logic         hl;
    bit held, done;
    int cyc;
    latency = -1; nBeats = 0; stallErr = 0; span = 0; held = 0; done = 0; cyc = 1;
    hd = '0; hr = '0; hl = 1'b0;
    for (int i = 0; i < 16; i++) begin beatData[i] = 'x; beatRound[i] = 'x; beatLast[i] = 1'bx; end
    while (!done && cyc < 300) begin
      start = 1'b0;
      if (pokeStart && $urandom_range(3) == 0) begin start = 1'b1; key_in = rand128(); end
      if (vValid) begin
        if (latency < 0) latency = cyc;
        if (held && (vData !== hd || vRound !== hr || vLast !== hl)) stallErr++;
        rk_ready = ($urandom_range(99) < readyPct);
        if (rk_ready) begin
          if (nBeats < 16) begin
            beatData[nBeats] = vData; beatRound[nBeats] = vRound; beatLast[nBeats] = vLast;
          end
          nBeats++;
          held = 0;
          if (vLast === 1'b1 || nBeats >= 16) begin
            done = 1;
            span = cyc - latency + 1;
            if (startOnLast) begin start = 1'b1; key_in = keyB; end
          end
        end else begin
          held = 1; hd = vData; hr = vRound; hl = vLast;
        end
      end else begin
        rk_ready = 1'($urandom_range(1));
        held = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; rk_ready = 1'b0;
    timedOut = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; startSkip = 1'b0; rk_ready = 1'b1; key_in = rand128(); useSkip = 0;
    repeat (3) @(posedge clk); #1;
    nVec++;
    if ({busy, rk_valid, rk_last, rk_round, rk_data} !== '0) begin
      nErr++;
      $display("[TB] FAIL reset_main: got %h, want 0", {busy, rk_valid, rk_last, rk_round, rk_data});
    end
    nVec++;
    if ({busyS, validS, lastS, roundS, dataS} !== '0) begin
      nErr++;
      $display("[TB] FAIL reset_skip: got %h, want 0", {busyS, validS, lastS, roundS, dataS});
    end
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    nVec++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL idle_ready: got busy=%b valid=%b, want 0 0", busy, rk_valid);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_fips();
    expandKey(FIPS_KEY);
    kick(0, FIPS_KEY);
    collect(100, 0, 0, '0);
    nVec++;
    if (timedOut || latency != 11 || nBeats != 11 || span != 11) begin
      nErr++;
      $display("[TB] FAIL fips timing: got timeout=%0d latency=%0d beats=%0d span=%0d, want 0 11 11 11",
               timedOut, latency, nBeats, span);
    end
    nVec++;
    if (beatData[0] !== FIPS_RK10 || beatData[9] !== FIPS_RK1 || beatData[10] !== FIPS_KEY) begin
      nErr++;
      $display("[TB] FAIL fips known: got rk10=%h rk1=%h rk0=%h, want %h %h %h",
               beatData[0], beatData[9], beatData[10], FIPS_RK10, FIPS_RK1, FIPS_KEY);
    end
    for (int i = 0; i < 11; i++) begin
      nVec++;
      if (beatData[i] !== rkModel[10-i] || beatRound[i] !== 4'(10-i) || beatLast[i] !== (i == 10)) begin
        nErr++;
        $display("[TB] FAIL fips beat %0d: got %h r%0d l%b, want %h r%0d l%b",
                 i, beatData[i], beatRound[i], beatLast[i], rkModel[10-i], 10-i, i == 10);
      end
    end
    nVec++;
    if (busy !== 1'b0) begin nErr++; $display("[TB] FAIL fips idle: got busy=%b, want 0", busy); end
  endtask

  task automatic test_skip_fwd();
    expandKey(FIPS_KEY);
    kick(1, FIPS_RK10);
    collect(100, 0, 0, '0);
    nVec++;
    if (timedOut || latency != 1 || nBeats != 11 || span != 11) begin
      nErr++;
      $display("[TB] FAIL skip timing: got timeout=%0d latency=%0d beats=%0d span=%0d, want 0 1 11 11",
               timedOut, latency, nBeats, span);
    end
    for (int i = 0; i < 11; i++) begin
      nVec++;
      if (beatData[i] !== rkModel[10-i] || beatRound[i] !== 4'(10-i) || beatLast[i] !== (i == 10)) begin
        nErr++;
        $display("[TB] FAIL skip beat %0d: got %h r%0d l%b, want %h r%0d l%b",
                 i, beatData[i], beatRound[i], beatLast[i], rkModel[10-i], 10-i, i == 10);
      end
    end
    nVec++;
    if (busyS !== 1'b0) begin nErr++; $display("[TB] FAIL skip idle: got busy=%b, want 0", busyS); end
  endtask

  task automatic test_zero_key();
    expandKey('0);
    kick(0, '0);
    collect(100, 0, 0, '0);
    nVec++;
    if (timedOut || nBeats != 11 || beatData[0] !== ZERO_RK10 || beatData[10] !== '0) begin
      nErr++;
      $display("[TB] FAIL zero_key: got beats=%0d rk10=%h rk0=%h, want 11 %h 0",
               nBeats, beatData[0], beatData[10], ZERO_RK10);
    end
    for (int i = 0; i < 11; i++) begin
      nVec++;
      if (beatData[i] !== rkModel[10-i] || beatRound[i] !== 4'(10-i)) begin
        nErr++;
        $display("[TB] FAIL zero beat %0d: got %h r%0d, want %h r%0d",
                 i, beatData[i], beatRound[i], rkModel[10-i], 10-i);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [127:0] key;
    for (int k = 0; k < 3; k++) begin
      key = rand128();
      expandKey(key);
      kick(0, key);
      collect(70, 1, 0, '0);
      nVec++;
      if (timedOut || latency != 11 || nBeats != 11 || stallErr != 0) begin
        nErr++;
        $display("[TB] FAIL start_ignored run %0d: got timeout=%0d latency=%0d beats=%0d stalls=%0d, want 0 11 11 0",
                 k, timedOut, latency, nBeats, stallErr);
      end
      for (int i = 0; i < 11; i++) begin
        nVec++;
        if (beatData[i] !== rkModel[10-i] || beatRound[i] !== 4'(10-i) || beatLast[i] !== (i == 10)) begin
          nErr++;
          $display("[TB] FAIL start_ignored beat %0d: got %h r%0d l%b, want %h r%0d l%b",
                   i, beatData[i], beatRound[i], beatLast[i], rkModel[10-i], 10-i, i == 10);
        end
      end
      nVec++;
      if (busy !== 1'b0 || rk_valid !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL start_ignored idle: got busy=%b valid=%b, want 0 0", busy, rk_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] keyA, keyB;
    keyA = rand128();
    keyB = rand128();
    expandKey(keyA);
    kick(0, keyA);
    collect(100, 0, 1, keyB);
    nVec++;
    if (timedOut || nBeats != 11 || beatData[10] !== keyA || beatData[0] !== rkModel[10]) begin
      nErr++;
      $display("[TB] FAIL b2b first: got beats=%0d rk10=%h rk0=%h, want 11 %h %h",
               nBeats, beatData[0], beatData[10], rkModel[10], keyA);
    end
    nVec++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL b2b start_on_last: got busy=%b valid=%b, want 0 0", busy, rk_valid);
    end
    expandKey(keyB);
    kick(0, keyB);
    nVec++;
    if (busy !== 1'b1) begin nErr++; $display("[TB] FAIL b2b restart: got busy=%b, want 1", busy); end
    collect(100, 0, 0, '0);
    nVec++;
    if (timedOut || latency != 11 || nBeats != 11) begin
      nErr++;
      $display("[TB] FAIL b2b second timing: got timeout=%0d latency=%0d beats=%0d, want 0 11 11",
               timedOut, latency, nBeats);
    end
    for (int i = 0; i < 11; i++) begin
      nVec++;
      if (beatData[i] !== rkModel[10-i] || beatRound[i] !== 4'(10-i)) begin
        nErr++;
        $display("[TB] FAIL b2b beat %0d: got %h r%0d, want %h r%0d",
                 i, beatData[i], beatRound[i], rkModel[10-i], 10-i);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [127:0] key;
    int n;
    key = rand128();
    expandKey(key);
    kick(0, key);
    rk_ready = 1'b1;
    n = 0;
    while (!(rk_valid === 1'b1 && rk_round === 4'd6) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    rk_ready = 1'b0;
    nVec++;
    if (n >= 40 || rk_data !== rkModel[6]) begin
      nErr++;
      $display("[TB] FAIL abort reach6: got cycles=%0d data=%h, want <40 %h", n, rk_data, rkModel[6]);
    end
    #2 rst_n = 1'b0;
    #1;
    nVec++;
    if ({busy, rk_valid, rk_last, rk_round, rk_data} !== '0) begin
      nErr++;
      $display("[TB] FAIL abort async: got %h, want 0", {busy, rk_valid, rk_last, rk_round, rk_data});
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    key = rand128();
    expandKey(key);
    kick(0, key);
    collect(100, 0, 0, '0);
    nVec++;
    if (timedOut || latency != 11 || nBeats != 11) begin
      nErr++;
      $display("[TB] FAIL abort restart: got timeout=%0d latency=%0d beats=%0d, want 0 11 11",
               timedOut, latency, nBeats);
    end
    for (int i = 0; i < 11; i++) begin
      nVec++;
      if (beatData[i] !== rkModel[10-i] || beatRound[i] !== 4'(10-i) || beatLast[i] !== (i == 10)) begin
        nErr++;
        $display("[TB] FAIL abort beat %0d: got %h r%0d l%b, want %h r%0d l%b",
                 i, beatData[i], beatRound[i], beatLast[i], rkModel[10-i], 10-i, i == 10);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] key;
    for (int k = 0; k < 50; k++) begin
      key = rand128();
      expandKey(key);
      if (k % 2 == 1) kick(1, rkModel[10]); else kick(0, key);
      collect(int'($urandom_range(20, 90)), 0, 0, '0);
      nVec++;
      if (timedOut || nBeats != 11 || stallErr != 0) begin
        nErr++;
        $display("[TB] FAIL bp key %0d: got timeout=%0d beats=%0d stall_changes=%0d, want 0 11 0",
                 k, timedOut, nBeats, stallErr);
      end
      for (int i = 0; i < 11; i++) begin
        nVec++;
        if (beatData[i] !== rkModel[10-i] || beatRound[i] !== 4'(10-i) || beatLast[i] !== (i == 10)) begin
          nErr++;
          $display("[TB] FAIL bp key %0d beat %0d: got %h r%0d l%b, want %h r%0d l%b",
                   k, i, beatData[i], beatRound[i], beatLast[i], rkModel[10-i], 10-i, i == 10);
        end
      end
      nVec++;
      if (vBusy !== 1'b0) begin nErr++; $display("[TB] FAIL bp key %0d idle: got busy=%b, want 0", k, vBusy); end
    end
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    start = 1'b0; startSkip = 1'b0; rk_ready = 1'b0; key_in = '0; rst_n = 1'b0; useSkip = 0;
    buildSbox();
    test_reset();
    test_fips();
    test_skip_fwd();
    test_zero_key();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
